// File: rtl/vga_pkg.sv
// Shared scan timing constants and types for the double-buffered VGA frame buffer.
package vga_pkg;

    localparam int unsigned SCAN_W   = 10;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_TOTAL  = 525;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_MAZE,
        REG_SCORE
    } region_e;

    // Per-pixel tag carried alongside the read address through the pipeline
    typedef struct packed {
        logic valid;
        logic hit;
        logic sel;
    } pix_tag_t;

endpackage

// File: rtl/vga_dbuf_fb_if.sv
// Renderer/scanout-facing bus of the frame buffer: scan position, write port, swap handshake, pixel out.
interface vga_dbuf_fb_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 16
);
    logic [vga_pkg::SCAN_W-1:0] hc;
    logic [vga_pkg::SCAN_W-1:0] vc;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       wr_ready;
    logic                       wr_done;
    logic                       swap_ack;
    logic                       wr_err;
    logic                       front_sel;
    logic [DATA_W-1:0]          pix_out;
    logic                       pix_valid;

    modport master (
        output hc, vc, wr_en, wr_addr, wr_data, wr_done,
        input  wr_ready, swap_ack, wr_err, front_sel, pix_out, pix_valid
    );

    modport slave (
        input  hc, vc, wr_en, wr_addr, wr_data, wr_done,
        output wr_ready, swap_ack, wr_err, front_sel, pix_out, pix_valid
    );
endinterface

// File: rtl/fb_bank.sv
// Single-port synchronous RAM bank: one write or one read per clock, 1-cycle read latency.
module fb_bank #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        dout <= r_mem[addr];
    end
endmodule

// File: rtl/vga_dbuf_fb.sv
// Ping-pong frame buffer: renderer fills the back bank, scanout reads the front bank,
// banks swap at frame end once the renderer has declared its frame complete.
module vga_dbuf_fb #(
    parameter int unsigned     DATA_W     = 8,
    parameter int unsigned     ADDR_W     = 16,
    parameter int unsigned     H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int unsigned     V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int unsigned     H_TOTAL    = vga_pkg::H_TOTAL,
    parameter int unsigned     V_TOTAL    = vga_pkg::V_TOTAL,
    parameter int unsigned     SCALE_SH   = 1,
    parameter int unsigned     ROTATE     = 1,
    parameter int unsigned     FB_W       = 240,
    parameter int unsigned     MAZE_Y0    = 24,
    parameter int unsigned     MAZE_H     = 264,
    parameter int unsigned     SCORE_X0   = 8,
    parameter int unsigned     SCORE_Y0   = 8,
    parameter int unsigned     SCORE_W    = 56,
    parameter int unsigned     SCORE_H    = 8,
    parameter int unsigned     SCORE_BASE = 63360,
    parameter logic [DATA_W-1:0] BG_COLOR = '0
) (
    input logic            clk,
    input logic            rst_n,
    vga_dbuf_fb_if.slave   bus
);
    localparam int unsigned SW = vga_pkg::SCAN_W;
    localparam int unsigned CW = ADDR_W + 2;

    logic               r_front_sel;
    logic               r_swap_pending;
    logic               r_swap_ack;
    logic               r_wr_err;
    logic [ADDR_W-1:0]  r_rd_addr;
    vga_pkg::pix_tag_t  r_s1;
    vga_pkg::pix_tag_t  r_s2;

    logic [CW-1:0]      w_h;
    logic [CW-1:0]      w_v;
    logic [CW-1:0]      w_x;
    logic [CW-1:0]      w_y;
    logic [CW-1:0]      w_maze_addr;
    logic [CW-1:0]      w_score_addr;
    logic [CW-1:0]      w_sel_addr;
    vga_pkg::region_e   w_region;
    logic               w_active;
    logic               w_hit;
    logic               w_frame_end;
    logic               w_wr_fire;
    logic [1:0]         w_we;
    logic [ADDR_W-1:0]  w_bank_addr [2];
    logic [DATA_W-1:0]  w_dout [2];

    // S0: scan position -> buffer (x,y) -> window region and bank address
    always_comb begin
        w_h = CW'(bus.hc) >> SCALE_SH;
        w_v = CW'(bus.vc) >> SCALE_SH;
        if (ROTATE != 0) begin
            w_x = CW'(FB_W - 1) - w_v;
            w_y = w_h;
        end else begin
            w_x = w_h;
            w_y = w_v;
        end

        w_maze_addr  = w_x + (w_y - CW'(MAZE_Y0)) * CW'(FB_W);
        w_score_addr = CW'(SCORE_BASE) + (w_x - CW'(SCORE_X0))
                     + (w_y - CW'(SCORE_Y0)) * CW'(SCORE_W);

        w_region   = vga_pkg::REG_NONE;
        w_sel_addr = '0;
        if (w_y >= CW'(MAZE_Y0) && w_y < CW'(MAZE_Y0 + MAZE_H)) begin
            w_region   = vga_pkg::REG_MAZE;
            w_sel_addr = w_maze_addr;
        end else if (w_x >= CW'(SCORE_X0) && w_x < CW'(SCORE_X0 + SCORE_W) &&
                     w_y >= CW'(SCORE_Y0) && w_y < CW'(SCORE_Y0 + SCORE_H)) begin
            w_region   = vga_pkg::REG_SCORE;
            w_sel_addr = w_score_addr;
        end

        w_active = (bus.hc < SW'(H_ACTIVE)) && (bus.vc < SW'(V_ACTIVE));
        // Anything that lands past the bank depth is treated as outside the windows
        w_hit    = w_active && (w_region != vga_pkg::REG_NONE)
                && (w_sel_addr[CW-1:ADDR_W] == '0);
    end

    assign w_frame_end = (bus.hc == SW'(H_TOTAL - 1)) && (bus.vc == SW'(V_TOTAL - 1));
    assign w_wr_fire   = bus.wr_en && !r_swap_pending;

    // Swap control, write-drop flag and read pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_front_sel    <= 1'b0;
            r_swap_pending <= 1'b0;
            r_swap_ack     <= 1'b0;
            r_wr_err       <= 1'b0;
            r_rd_addr      <= '0;
            r_s1           <= '0;
            r_s2           <= '0;
        end else begin
            r_wr_err   <= bus.wr_en && r_swap_pending;
            r_swap_ack <= 1'b0;
            if (w_frame_end && (r_swap_pending || bus.wr_done)) begin
                r_front_sel    <= ~r_front_sel;
                r_swap_pending <= 1'b0;
                r_swap_ack     <= 1'b1;
            end else if (bus.wr_done) begin
                r_swap_pending <= 1'b1;
            end

            r_rd_addr  <= w_sel_addr[ADDR_W-1:0];
            r_s1.valid <= w_active;
            r_s1.hit   <= w_hit;
            r_s1.sel   <= r_front_sel;
            r_s2       <= r_s1;
        end
    end

    // The back bank owns the write port; the front bank is always reading
    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_we[b]        = w_wr_fire && (r_front_sel != 1'(b));
        assign w_bank_addr[b] = w_we[b] ? bus.wr_addr : r_rd_addr;

        fb_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk  (clk),
            .we   (w_we[b]),
            .addr (w_bank_addr[b]),
            .din  (bus.wr_data),
            .dout (w_dout[b])
        );
    end

    assign bus.wr_ready  = ~r_swap_pending;
    assign bus.swap_ack  = r_swap_ack;
    assign bus.wr_err    = r_wr_err;
    assign bus.front_sel = r_front_sel;
    assign bus.pix_valid = r_s2.valid;
    assign bus.pix_out   = (r_s2.valid && r_s2.hit) ? w_dout[r_s2.sel] : BG_COLOR;

endmodule

// File: tb/tb_vga_dbuf_fb.sv
// Self-checking bench for vga_dbuf_fb: directed scenarios plus randomized traffic against a behavioural model.
module tb_vga_dbuf_fb;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 16;
    localparam int FB_W       = 240;
    localparam int MAZE_Y0    = 24;
    localparam int MAZE_H     = 264;
    localparam int SCORE_X0   = 8;
    localparam int SCORE_Y0   = 8;
    localparam int SCORE_W    = 56;
    localparam int SCORE_H    = 8;
    localparam int SCORE_BASE = 63360;
    localparam logic [7:0] BG = 8'h00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_dbuf_fb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    vga_dbuf_fb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit live     = 1'b0;

    // Reference model state
    logic [7:0] m_bank0 [int];
    logic [7:0] m_bank1 [int];
    int         m_front;
    bit         m_pend;
    bit         s1_pv, s1_known;
    logic [7:0] s1_pix;
    bit         exp_front, exp_ready, exp_ack, exp_err, exp_pv, exp_known;
    logic [7:0] exp_pix;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic void m_write(input int bank, input int a, input logic [7:0] d);
        if (bank == 0) m_bank0[a] = d;
        else           m_bank1[a] = d;
    endfunction

    // What the screen should show at (h,v) when scanning the given bank
    function automatic void ref_pixel(input int h, input int v, input int bank,
                                      output bit valid, output bit known, output logic [7:0] val);
        int x, y, a;
        bit hit;
        valid = (h < 640) && (v < 480);
        x = FB_W - 1 - (v / 2);
        y = h / 2;
        hit = 1'b0;
        a = 0;
        if (y >= MAZE_Y0 && y < MAZE_Y0 + MAZE_H) begin
            hit = 1'b1;
            a = x + (y - MAZE_Y0) * FB_W;
        end else if (x >= SCORE_X0 && x < SCORE_X0 + SCORE_W &&
                     y >= SCORE_Y0 && y < SCORE_Y0 + SCORE_H) begin
            hit = 1'b1;
            a = SCORE_BASE + (x - SCORE_X0) + (y - SCORE_Y0) * SCORE_W;
        end
        if (a < 0 || a >= 65536) hit = 1'b0;
        known = 1'b1;
        val = BG;
        if (valid && hit) begin
            if (bank == 0 && m_bank0.exists(a))      val = m_bank0[a];
            else if (bank == 1 && m_bank1.exists(a)) val = m_bank1[a];
            else                                     known = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        m_front = 0;   m_pend = 1'b0;
        s1_pv = 1'b0;  s1_known = 1'b1; s1_pix = BG;
        exp_front = 1'b0; exp_ready = 1'b1; exp_ack = 1'b0; exp_err = 1'b0;
        exp_pv = 1'b0; exp_known = 1'b1; exp_pix = BG;
    endfunction

    // Drive one clock of scan position and write traffic, then advance the model across the edge
    task automatic tick(input int h, input int v, input bit en, input int addr,
                        input logic [7:0] d, input bit done);
        bit pv, kn;
        logic [7:0] pval;
        bus.hc      = 10'(h);
        bus.vc      = 10'(v);
        bus.wr_en   = en;
        bus.wr_addr = 16'(addr);
        bus.wr_data = d;
        bus.wr_done = done;
        @(posedge clk);
        exp_err = en && m_pend;
        if (en && !m_pend) m_write(1 - m_front, addr, d);
        ref_pixel(h, v, m_front, pv, kn, pval);
        exp_pv = s1_pv; exp_pix = s1_pix; exp_known = s1_known;
        s1_pv = pv;     s1_pix = pval;    s1_known = kn;
        exp_ack = 1'b0;
        if (h == 799 && v == 524 && (m_pend || done)) begin
            m_front = 1 - m_front;
            m_pend  = 1'b0;
            exp_ack = 1'b1;
        end else if (done) begin
            m_pend = 1'b1;
        end
        exp_front = (m_front == 1);
        exp_ready = !m_pend;
        #1;
    endtask

    task automatic idle(input int h, input int v);
        tick(h, v, 1'b0, 0, 8'h00, 1'b0);
    endtask

    task automatic wr(input int h, input int v, input int a, input logic [7:0] d);
        tick(h, v, 1'b1, a, d, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.wr_en = 1'b0; bus.wr_done = 1'b0; bus.hc = '0; bus.vc = '0;
        bus.wr_addr = '0; bus.wr_data = '0;
        repeat (2) @(posedge clk);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n && live) begin
            chk("front_sel", int'(bus.front_sel), int'(exp_front));
            chk("wr_ready",  int'(bus.wr_ready),  int'(exp_ready));
            chk("swap_ack",  int'(bus.swap_ack),  int'(exp_ack));
            chk("wr_err",    int'(bus.wr_err),    int'(exp_err));
            chk("pix_valid", int'(bus.pix_valid), int'(exp_pv));
            if (exp_known) chk("pix_out", int'(bus.pix_out), int'(exp_pix));
        end
    end

    initial begin
        model_reset();
        bus.wr_en = 1'b0; bus.wr_done = 1'b0; bus.hc = '0; bus.vc = '0;
        bus.wr_addr = '0; bus.wr_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        live = 1'b1;

        // Reset values
        chk("rst_front_sel", int'(bus.front_sel), 0);
        chk("rst_wr_ready",  int'(bus.wr_ready),  1);
        chk("rst_swap_ack",  int'(bus.swap_ack),  0);
        chk("rst_wr_err",    int'(bus.wr_err),    0);
        chk("rst_pix_valid", int'(bus.pix_valid), 0);
        chk("rst_pix_out",   int'(bus.pix_out),   int'(BG));

        // No writes, no wr_done: frame end keeps the same front bank
        for (int i = 0; i < 100; i++) idle($urandom_range(48, 575), $urandom_range(0, 479));
        idle(799, 524);
        chk("noswap_ack",   int'(bus.swap_ack),  0);
        chk("noswap_front", int'(bus.front_sel), 0);

        // Fill back bank 1, declare the frame done on line 100, swap at frame end
        wr(0, 0, 0, 8'h5A);
        wr(1, 0, 239, 8'h77);
        tick(0, 100, 1'b0, 0, 8'h00, 1'b1);
        chk("pend_ready", int'(bus.wr_ready), 0);
        idle(798, 524);
        idle(799, 524);
        chk("swap1_ack",   int'(bus.swap_ack),  1);
        chk("swap1_front", int'(bus.front_sel), 1);
        idle(0, 0);
        chk("swap1_ack_pulse", int'(bus.swap_ack), 0);
        idle(48, 0);
        idle(49, 0);
        chk("addr239_pix",   int'(bus.pix_out),   8'h77);
        chk("addr239_valid", int'(bus.pix_valid), 1);
        idle(48, 478);
        idle(49, 478);
        chk("addr0_pix", int'(bus.pix_out), 8'h5A);

        // Writes while a swap is pending are dropped and flagged
        wr(0, 1, 479, 8'h11);
        tick(0, 200, 1'b0, 0, 8'h00, 1'b1);
        wr(5, 200, 479, 8'hEE);
        chk("drop_err",   int'(bus.wr_err),   1);
        chk("drop_ready", int'(bus.wr_ready), 0);
        idle(6, 200);
        chk("drop_err_pulse", int'(bus.wr_err), 0);
        tick(0, 201, 1'b0, 0, 8'h00, 1'b1);
        idle(799, 524);
        chk("swap2_front", int'(bus.front_sel), 0);
        chk("swap2_ready", int'(bus.wr_ready),  1);
        idle(50, 0);
        idle(51, 0);
        chk("dropped_kept", int'(bus.pix_out), 8'h11);

        // wr_done right on the frame-end cycle, then a bare second wr_done swaps back
        tick(799, 524, 1'b0, 0, 8'h00, 1'b1);
        chk("fe_done_ack",   int'(bus.swap_ack),  1);
        chk("fe_done_front", int'(bus.front_sel), 1);
        tick(10, 10, 1'b0, 0, 8'h00, 1'b1);
        idle(799, 524);
        chk("swapback_front", int'(bus.front_sel), 0);

        // Score window pixel at buffer (11,8)
        wr(0, 2, SCORE_BASE + 3, 8'hC3);
        tick(0, 3, 1'b0, 0, 8'h00, 1'b1);
        idle(799, 524);
        idle(16, 456);
        idle(17, 456);
        chk("score_pix", int'(bus.pix_out), 8'hC3);

        // Reset mid-frame while a swap is pending
        tick(5, 300, 1'b0, 0, 8'h00, 1'b1);
        apply_reset();
        chk("midrst_front", int'(bus.front_sel), 0);
        chk("midrst_ready", int'(bus.wr_ready),  1);
        idle(799, 524);
        chk("midrst_noack", int'(bus.swap_ack),  0);

        // Randomized traffic concentrated on window edges
        for (int i = 0; i < 4000; i++) begin
            int sel, h, v, a;
            bit en, dn;
            sel = int'($urandom_range(0, 99));
            if (sel < 10) begin
                h = 799; v = 524;
            end else if (sel < 55) begin
                h = int'($urandom_range(40, 63));  v = int'($urandom_range(0, 11));
            end else if (sel < 80) begin
                h = int'($urandom_range(14, 33));  v = int'($urandom_range(340, 479));
            end else begin
                h = int'($urandom_range(0, 799));  v = int'($urandom_range(0, 524));
            end
            en = ($urandom_range(0, 99) < 40);
            a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(63360, 63807))
                                             : int'($urandom_range(0, 1919));
            dn = ($urandom_range(0, 49) == 0);
            tick(h, v, en, a, 8'($urandom), dn);
        end
        idle(0, 0);
        idle(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
